// File: rtl/jtag_debug_pkg.sv
// Shared definitions for the debug-slave scan master.
//   - scan_state_e : scan sequencer states
//   - DefDrWidth / DefIrWidth : default shift-register and virtual-IR widths
//   - Ir* : virtual IR codes understood by the debug slave
package jtag_debug_pkg;

   localparam int unsigned DefDrWidth = 38;
   localparam int unsigned DefIrWidth = 2;

   localparam logic [1:0] IrOcimem    = 2'd0;
   localparam logic [1:0] IrTracemem  = 2'd1;
   localparam logic [1:0] IrBreak     = 2'd2;
   localparam logic [1:0] IrTracectrl = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StUir,
      StCdr,
      StSdr,
      StUdr,
      StRsp
   } scan_state_e;

endpackage

// File: rtl/jtag_debug_tck_gen.sv
// Scan-clock generator. While en is high it produces a tck period of 2*TCK_DIV clk cycles,
// a low half followed by a high half. While en is low, tck is 0 and the divider is cleared.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   en           : run the divider
//   tck          : generated scan clock (registered)
//   fall         : high in the cycle whose closing edge drives tck to 0 (period end)
//   rise         : high in the cycle whose closing edge drives tck to 1
module jtag_debug_tck_gen #(
   parameter int unsigned TCK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tck,
   output logic fall,
   output logic rise
);

   localparam int unsigned Period = 2 * TCK_DIV;
   localparam int unsigned CntW   = (Period > 2) ? $clog2(Period) : 1;
   localparam logic [CntW-1:0] RiseCnt = CntW'(TCK_DIV - 1);
   localparam logic [CntW-1:0] FallCnt = CntW'(Period - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tck_q, tck_d;

   always_comb begin
      rise  = en && (cnt_q == RiseCnt);
      fall  = en && (cnt_q == FallCnt);
      cnt_d = '0;
      tck_d = 1'b0;
      if (en) begin
         cnt_d = fall ? '0 : cnt_q + CntW'(1);
         tck_d = rise ? 1'b1 : (fall ? 1'b0 : tck_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

   assign tck = tck_q;

endmodule

// File: rtl/jtag_debug_scan_master.sv
// Sysclk-domain scan initiator for the virtual-JTAG side of a debug slave. Accepts one
// IR+DR scan command, walks UIR -> CDR -> SDR(DR_WIDTH tck periods) -> UDR, and returns
// the tdo bits captured during SDR together with the slave's status IR.
// Ports:
//   clk, reset_n                    : system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_ir/cmd_data : scan command (data shifted out LSB first)
//   rsp_valid/rsp_ready/rsp_data/rsp_ir_out : scan response
//   vji_tck/vji_tdi/vji_tdo         : scan clock and serial data
//   vji_ir_in/vji_ir_out            : virtual IR to the slave / status IR from the slave
//   vji_uir/cdr/sdr/udr/rti         : virtual-state strobes
module jtag_debug_scan_master
   import jtag_debug_pkg::*;
#(
   parameter int unsigned DR_WIDTH = DefDrWidth,
   parameter int unsigned IR_WIDTH = DefIrWidth,
   parameter int unsigned TCK_DIV  = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_data,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int unsigned BitW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

   scan_state_e         state_q, state_d;
   logic [DR_WIDTH-1:0] sr_q, sr_d;
   logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
   logic [BitW-1:0]     bit_q, bit_d;
   logic                done_q, done_d;
   logic                tdi_q, tdi_d;
   logic                tck_en, fall, rise;

   assign tck_en = (state_q != StIdle) && (state_q != StRsp);

   jtag_debug_tck_gen #(
      .TCK_DIV (TCK_DIV)
   ) u_tck_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (tck_en),
      .tck     (vji_tck),
      .fall    (fall),
      .rise    (rise)
   );

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      rsp_data_d = rsp_data_q;
      ir_d       = ir_q;
      rsp_ir_d   = rsp_ir_q;
      bit_d      = bit_q;
      done_d     = done_q;
      tdi_d      = tdi_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               state_d = StUir;
               sr_d    = cmd_data;
               ir_d    = cmd_ir;
            end
         end
         StUir: begin
            if (fall) state_d = StCdr;
         end
         StCdr: begin
            if (fall) begin
               state_d = StSdr;
               tdi_d   = sr_q[0];
               bit_d   = BitW'(DR_WIDTH - 1);
               done_d  = 1'b0;
            end
         end
         StSdr: begin
            // rise and fall are never in the same cycle, so these branches are exclusive.
            if (rise) begin
               sr_d               = sr_q >> 1;
               sr_d[DR_WIDTH-1]   = vji_tdo;
               if (bit_q == '0) begin
                  bit_d  = BitW'(DR_WIDTH - 1);
                  done_d = 1'b1;
               end else begin
                  bit_d = bit_q - BitW'(1);
               end
            end
            if (fall) begin
               if (done_q) begin
                  state_d = StUdr;
                  tdi_d   = 1'b0;
                  done_d  = 1'b0;
               end else begin
                  tdi_d = sr_q[0];
               end
            end
         end
         StUdr: begin
            if (rise) rsp_ir_d = vji_ir_out;
            if (fall) begin
               state_d    = StRsp;
               rsp_data_d = sr_q;
            end
         end
         StRsp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         sr_q       <= '0;
         rsp_data_q <= '0;
         ir_q       <= '0;
         rsp_ir_q   <= '0;
         bit_q      <= '0;
         done_q     <= 1'b0;
         tdi_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         rsp_data_q <= rsp_data_d;
         ir_q       <= ir_d;
         rsp_ir_q   <= rsp_ir_d;
         bit_q      <= bit_d;
         done_q     <= done_d;
         tdi_q      <= tdi_d;
      end
   end

   assign cmd_ready  = (state_q == StIdle);
   assign vji_rti    = (state_q == StIdle);
   assign rsp_valid  = (state_q == StRsp);
   assign rsp_data   = rsp_data_q;
   assign rsp_ir_out = rsp_ir_q;
   assign vji_tdi    = tdi_q;
   assign vji_ir_in  = ir_q;
   assign vji_uir    = (state_q == StUir);
   assign vji_cdr    = (state_q == StCdr);
   assign vji_sdr    = (state_q == StSdr);
   assign vji_udr    = (state_q == StUdr);

endmodule
